seg_scan4: RTL and testbench

//   Multiplexed 4-digit seven-segment driver; sits directly downstream of the count60 counter chain.

---
 rtl/seg_scan4.sv | 137 +++++++++++++
 tb/tb_seg_scan4.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan4.sv
// seg_scan4: multiplexed 4-digit seven-segment driver.
// Scans four BCD digits onto one shared segment bus. Each digit slot lasts
// REFRESH_DIV clocks. The first cycle of every slot blanks all anodes so the
// previous digit does not ghost. an/seg/dp are registered and are inverted in
// the output register when ACTIVE_LOW=1.
// Optional feature: define SEG_LZB_EN to enable leading-zero blanking.
module seg_scan4 #(
    parameter int REFRESH_DIV = 100000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic       ck,
    input  logic       rst,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] dp_mask,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int             PW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]  PCNT_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [3:0]     AN_POL   = {4{ACTIVE_LOW}};
    localparam logic [6:0]     SEG_POL  = {7{ACTIVE_LOW}};

    // BCD to active-high segments (g..a); codes 10..15 show a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    logic [PW-1:0] r_pcnt;
    logic [1:0]    r_slot;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic [3:0]    w_digit;
    logic          w_dp_bit;
    logic          w_blank;
    logic [3:0]    w_an_next;
    logic [6:0]    w_seg_next;

    // Prescaler and slot counter; slot advances when the prescaler wraps.
    always_ff @(posedge ck) begin
        if (rst) begin
            r_pcnt <= {PW{1'b0}};
            r_slot <= 2'd0;
        end else if (r_pcnt == PCNT_MAX) begin
            r_pcnt <= {PW{1'b0}};
            r_slot <= r_slot + 2'd1;
        end else begin
            r_pcnt <= r_pcnt + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    // Select the current slot's digit and decimal-point bit (read live, not latched).
    always_comb begin
        w_digit  = 4'd0;
        w_dp_bit = 1'b0;
        case (r_slot)
            2'd0:    begin w_digit = digit0; w_dp_bit = dp_mask[0]; end
            2'd1:    begin w_digit = digit1; w_dp_bit = dp_mask[1]; end
            2'd2:    begin w_digit = digit2; w_dp_bit = dp_mask[2]; end
            2'd3:    begin w_digit = digit3; w_dp_bit = dp_mask[3]; end
            default: begin w_digit = 4'd0;   w_dp_bit = 1'b0;       end
        endcase
    end

`ifdef SEG_LZB_EN
    logic [3:0] w_lead_zero;

    // Leading-zero chain: a digit is blanked when it and every higher digit is zero.
    always_comb begin
        w_lead_zero    = 4'b0000;
        w_lead_zero[3] = (digit3 == 4'd0);
        w_lead_zero[2] = w_lead_zero[3] && (digit2 == 4'd0);
        w_lead_zero[1] = w_lead_zero[2] && (digit1 == 4'd0);
        w_lead_zero[0] = 1'b0;
        w_blank        = w_lead_zero[r_slot];
    end
`else
    // Without leading-zero blanking every digit is always decoded.
    always_comb begin
        w_blank = 1'b0;
    end
`endif

    // Next active-high anode and segment values; anodes are all off in the gap cycle.
    always_comb begin
        w_an_next  = 4'b0000;
        w_seg_next = 7'h00;
        if (r_pcnt == {PW{1'b0}}) begin
            w_an_next = 4'b0000;
        end else begin
            w_an_next = 4'b0001 << r_slot;
        end
        if (w_blank) begin
            w_seg_next = 7'h00;
        end else begin
            w_seg_next = bcd_to_seg(w_digit);
        end
    end

    // Output register; polarity is applied only here.
    always_ff @(posedge ck) begin
        if (rst) begin
            r_an  <= AN_POL;
            r_seg <= SEG_POL;
            r_dp  <= ACTIVE_LOW;
        end else begin
            r_an  <= w_an_next ^ AN_POL;
            r_seg <= w_seg_next ^ SEG_POL;
            r_dp  <= w_dp_bit ^ ACTIVE_LOW;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_seg_scan4.sv
// Testbench for seg_scan4: directed scenarios plus randomized digit/reset
// traffic checked against a time-based reference model. Two instances run in
// parallel, one active-high and one active-low, both with REFRESH_DIV=4.
module tb_seg_scan4;

    localparam int DIV = 4;

    logic       ck;
    logic       rst;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [3:0] dp_mask;
    logic [3:0] an_h, an_l;
    logic [6:0] seg_h, seg_l;
    logic       dp_h, dp_l;

    int checks_r;
    int errors_r;
    int n_edges_r;

    logic [6:0] seg_tab [0:15];
    logic [3:0] an_seq  [0:5];

    seg_scan4 #(.REFRESH_DIV(DIV), .ACTIVE_LOW(1'b0)) u_dut_h (
        .ck(ck), .rst(rst),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .dp_mask(dp_mask),
        .an(an_h), .seg(seg_h), .dp(dp_h)
    );

    seg_scan4 #(.REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1)) u_dut_l (
        .ck(ck), .rst(rst),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .dp_mask(dp_mask),
        .an(an_l), .seg(seg_l), .dp(dp_l)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: observed 0x%02h expected 0x%02h at time %0t", tag, obs, exp, $time);
        end
    endtask

    // Segment pattern the display should show for slot s, given the live digits.
    function automatic logic [6:0] model_seg(input int s);
        logic [3:0] d [0:3];
        d[0] = digit0; d[1] = digit1; d[2] = digit2; d[3] = digit3;
`ifdef SEG_LZB_EN
        if (s > 0) begin
            bit all_zero;
            all_zero = 1'b1;
            for (int k = s; k < 4; k++) begin
                if (d[k] != 4'd0) all_zero = 1'b0;
            end
            if (all_zero) return 7'h00;
        end
`endif
        return seg_tab[d[s]];
    endfunction

    // One clock: predict from the inputs and elapsed time, then compare after the edge.
    task automatic tick();
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        int p, s;
        if (rst) begin
            exp_an = 4'b0000; exp_seg = 7'h00; exp_dp = 1'b0;
        end else begin
            p = n_edges_r % DIV;
            s = (n_edges_r / DIV) % 4;
            exp_an  = (p == 0) ? 4'b0000 : (4'b0001 << s);
            exp_seg = model_seg(s);
            exp_dp  = dp_mask[s];
        end
        @(posedge ck);
        #1;
        check_val("an",     {4'b0000, an_h},  {4'b0000, exp_an});
        check_val("seg",    {1'b0, seg_h},    {1'b0, exp_seg});
        check_val("dp",     {7'b0, dp_h},     {7'b0, exp_dp});
        check_val("an_lo",  {4'b0000, an_l},  {4'b0000, ~exp_an});
        check_val("seg_lo", {1'b0, seg_l},    {1'b0, ~exp_seg});
        check_val("dp_lo",  {7'b0, dp_l},     {7'b0, ~exp_dp});
        if (rst) n_edges_r = 0;
        else     n_edges_r++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                              input logic [3:0] d1, input logic [3:0] d0);
        digit3 = d3; digit2 = d2; digit1 = d1; digit0 = d0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        run(n);
        rst = 1'b0;
    endtask

    initial begin
        int r;
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        an_seq  = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010};
        checks_r  = 0;
        errors_r  = 0;
        n_edges_r = 0;
        rst       = 1'b1;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        dp_mask   = 4'b0000;
        @(negedge ck);

        // Reset and scan order.
        do_reset(3);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val("an_seq", {4'b0000, an_h}, {4'b0000, an_seq[i]});
        end
        run(14);

        // Decode, dp on slot 2 only.
        set_digits(4'd9, 4'd4, 4'd1, 4'd0);
        dp_mask = 4'b0100;
        do_reset(1);
        run(20);

        // Invalid BCD on slot 1.
        digit1 = 4'hC;
        run(16);

        // Mid-slot update on slot 0.
        set_digits(4'd1, 4'd2, 4'd5, 4'd3);
        dp_mask = 4'b0000;
        do_reset(1);
        run(2);
        digit0 = 4'd8;
        tick();
        check_val("midslot_seg", {1'b0, seg_h}, 8'h7F);
        check_val("midslot_an",  {4'b0000, an_h}, 8'h01);
        run(4);

        // Reset mid-scan at slot 2, pcnt 2.
        do_reset(1);
        run(2 * DIV + 2);
        do_reset(1);
        check_val("midrst_an", {4'b0000, an_h}, 8'h00);
        run(2);
        check_val("restart_an", {4'b0000, an_h}, 8'h01);
        run(4);

        // Leading zeros (blanked only when SEG_LZB_EN is defined).
        set_digits(4'd0, 4'd0, 4'd5, 4'd7);
        run(16);
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        dp_mask = 4'b1010;
        run(16);
        set_digits(4'd0, 4'hB, 4'd0, 4'd0);
        run(16);

        // Randomized traffic, biased toward zeros so blanking gets exercised.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 15);
            if (r < 3) begin
                logic [3:0] v;
                v = ($urandom_range(0, 9) < 4) ? 4'd0 : 4'($urandom_range(0, 15));
                case ($urandom_range(0, 3))
                    0:       digit0 = v;
                    1:       digit1 = v;
                    2:       digit2 = v;
                    default: digit3 = v;
                endcase
            end
            if (r == 5) dp_mask = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        run(4);

        $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
        $finish;
    end

endmodule
